// File: rtl/model_matrix_streamer_pkg.sv
// Shared types and constants for the matrix staging block.
// The FSM state encoding and the replay-order selector values live here.
package model_matrix_streamer_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam logic MODE_ROW_MAJOR = 1'b0;
  localparam logic MODE_TRANSPOSE = 1'b1;

endpackage

// File: rtl/model_matrix_streamer_if.sv
// Control, input-stream and output-stream bundle of the matrix staging block.
// slave is the block side; master is the producer/consumer/controller side.
interface model_matrix_streamer_if #(
  parameter int DATA_SIZE = 64
);
  logic                 START;
  logic                 READY;
  logic                 BUSY;
  logic                 ERROR;
  logic                 TRANSPOSE;
  logic [DATA_SIZE-1:0] SIZE_I_IN;
  logic [DATA_SIZE-1:0] SIZE_J_IN;
  logic [DATA_SIZE-1:0] DATA_IN;
  logic                 DATA_IN_VALID;
  logic                 DATA_IN_READY;
  logic [DATA_SIZE-1:0] DATA_OUT;
  logic                 DATA_OUT_VALID;
  logic                 DATA_OUT_READY;
  logic                 DATA_OUT_I_ENABLE;
  logic                 DATA_OUT_J_ENABLE;
  logic                 DATA_OUT_LAST;

  modport slave (
    input  START, TRANSPOSE, SIZE_I_IN, SIZE_J_IN, DATA_IN, DATA_IN_VALID, DATA_OUT_READY,
    output READY, BUSY, ERROR, DATA_IN_READY, DATA_OUT, DATA_OUT_VALID,
           DATA_OUT_I_ENABLE, DATA_OUT_J_ENABLE, DATA_OUT_LAST
  );

  modport master (
    output START, TRANSPOSE, SIZE_I_IN, SIZE_J_IN, DATA_IN, DATA_IN_VALID, DATA_OUT_READY,
    input  READY, BUSY, ERROR, DATA_IN_READY, DATA_OUT, DATA_OUT_VALID,
           DATA_OUT_I_ENABLE, DATA_OUT_J_ENABLE, DATA_OUT_LAST
  );
endinterface

// File: rtl/model_matrix_streamer_buffer.sv
// Element store for one staged matrix: synchronous write, combinational read.
// Contents are deliberately not reset; every legal operation rewrites what it reads.
module model_matrix_streamer_buffer #(
  parameter int DATA_SIZE = 64,
  parameter int ADDR_SIZE = 6
) (
  input  logic                 CLK,
  input  logic                 wr_en,
  input  logic [ADDR_SIZE-1:0] wr_addr,
  input  logic [DATA_SIZE-1:0] wr_data,
  input  logic [ADDR_SIZE-1:0] rd_addr,
  output logic [DATA_SIZE-1:0] rd_data
);

  logic [DATA_SIZE-1:0] mem [2**ADDR_SIZE];

  always_ff @(posedge CLK) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  assign rd_data = mem[rd_addr];

endmodule

// File: rtl/model_matrix_streamer.sv
// Captures an I x J matrix in row-major order and replays it row-major or transposed,
// with per-line strobes and a one-deep output register that honours backpressure.
module model_matrix_streamer
  import model_matrix_streamer_pkg::*;
#(
  parameter int DATA_SIZE = 64,
  parameter int ADDR_SIZE = 6
) (
  input  logic                  CLK,
  input  logic                  RST,
  model_matrix_streamer_if.slave bus
);

  localparam int CW = ADDR_SIZE + 1;
  typedef logic [CW-1:0] cnt_t;
  localparam cnt_t ONE = cnt_t'(1);
  localparam logic [2*DATA_SIZE-1:0] DEPTH = (2*DATA_SIZE)'(1) << ADDR_SIZE;

  state_t               state_reg, state_next;
  cnt_t                 size_i_reg, size_j_reg, total_reg;
  cnt_t                 i_reg, j_reg, issue_reg;
  logic                 transpose_reg, error_reg;
  logic [DATA_SIZE-1:0] out_data_reg;
  logic                 out_valid_reg, out_i_en_reg, out_last_reg;

  logic [2*DATA_SIZE-1:0] size_prod;
  logic                   size_zero, size_over;
  logic                   in_fire, load_last, out_fire, drain_load, inner_zero;
  logic                   i_at_end, j_at_end;
  logic [ADDR_SIZE-1:0]   buf_addr;
  logic [DATA_SIZE-1:0]   rd_data;

  assign size_prod  = (2*DATA_SIZE)'(bus.SIZE_I_IN) * (2*DATA_SIZE)'(bus.SIZE_J_IN);
  assign size_zero  = (size_prod == '0);
  assign size_over  = (size_prod > DEPTH);

  assign i_at_end   = (i_reg == size_i_reg - ONE);
  assign j_at_end   = (j_reg == size_j_reg - ONE);
  assign in_fire    = (state_reg == LOAD) && bus.DATA_IN_VALID;
  assign load_last  = in_fire && i_at_end && j_at_end;
  assign out_fire   = out_valid_reg && bus.DATA_OUT_READY;
  assign drain_load = (state_reg == DRAIN) && (!out_valid_reg || bus.DATA_OUT_READY)
                      && (issue_reg != total_reg);
  assign inner_zero = (transpose_reg == MODE_TRANSPOSE) ? (i_reg == '0) : (j_reg == '0);

  // Load and drain share one address: i*J + j, whatever the replay order.
  assign buf_addr = ADDR_SIZE'(i_reg * size_j_reg) + ADDR_SIZE'(j_reg);

  model_matrix_streamer_buffer #(
    .DATA_SIZE (DATA_SIZE),
    .ADDR_SIZE (ADDR_SIZE)
  ) u_buffer (
    .CLK     (CLK),
    .wr_en   (in_fire),
    .wr_addr (buf_addr),
    .wr_data (bus.DATA_IN),
    .rd_addr (buf_addr),
    .rd_data (rd_data)
  );

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (bus.START) state_next = (size_zero || size_over) ? DONE : LOAD;
      LOAD:    if (load_last) state_next = DRAIN;
      DRAIN:   if (out_fire && out_last_reg) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      size_i_reg    <= '0;
      size_j_reg    <= '0;
      total_reg     <= '0;
      transpose_reg <= 1'b0;
      error_reg     <= 1'b0;
      i_reg         <= '0;
      j_reg         <= '0;
      issue_reg     <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (bus.START) begin
            size_i_reg    <= bus.SIZE_I_IN[CW-1:0];
            size_j_reg    <= bus.SIZE_J_IN[CW-1:0];
            total_reg     <= size_prod[CW-1:0];
            transpose_reg <= bus.TRANSPOSE;
            error_reg     <= !size_zero && size_over;
            i_reg         <= '0;
            j_reg         <= '0;
            issue_reg     <= '0;
          end
        end
        LOAD: begin
          if (in_fire) begin
            if (j_at_end) begin
              j_reg <= '0;
              i_reg <= i_at_end ? '0 : i_reg + ONE;
            end else begin
              j_reg <= j_reg + ONE;
            end
          end
        end
        DRAIN: begin
          if (drain_load) begin
            issue_reg <= issue_reg + ONE;
            if (transpose_reg == MODE_TRANSPOSE) begin
              if (i_at_end) begin
                i_reg <= '0;
                j_reg <= j_reg + ONE;
              end else begin
                i_reg <= i_reg + ONE;
              end
            end else if (j_at_end) begin
              j_reg <= '0;
              i_reg <= i_reg + ONE;
            end else begin
              j_reg <= j_reg + ONE;
            end
          end
        end
        default: ;
      endcase
    end
  end

  // Output register reloads only when empty or being consumed, so a stall holds everything.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      out_data_reg  <= '0;
      out_valid_reg <= 1'b0;
      out_i_en_reg  <= 1'b0;
      out_last_reg  <= 1'b0;
    end else if (drain_load) begin
      out_data_reg  <= rd_data;
      out_valid_reg <= 1'b1;
      out_i_en_reg  <= inner_zero;
      out_last_reg  <= (issue_reg == total_reg - ONE);
    end else if (out_fire) begin
      out_valid_reg <= 1'b0;
      out_i_en_reg  <= 1'b0;
      out_last_reg  <= 1'b0;
    end
  end

  assign bus.READY             = (state_reg == DONE);
  assign bus.ERROR             = (state_reg == DONE) && error_reg;
  assign bus.BUSY              = (state_reg != IDLE);
  assign bus.DATA_IN_READY     = (state_reg == LOAD);
  assign bus.DATA_OUT          = out_data_reg;
  assign bus.DATA_OUT_VALID    = out_valid_reg;
  assign bus.DATA_OUT_I_ENABLE = out_i_en_reg;
  assign bus.DATA_OUT_J_ENABLE = out_valid_reg;
  assign bus.DATA_OUT_LAST     = out_last_reg;

endmodule

// File: tb/tb_model_matrix_streamer.sv
// Directed bench for the matrix staging block: stimulus pushes expected elements and
// completion status into queues, a negedge monitor pops and compares them.
module tb_model_matrix_streamer;

  localparam int DW = 64;

  logic CLK = 1'b0;
  logic RST = 1'b0;
  always #5 CLK = ~CLK;

  model_matrix_streamer_if #(.DATA_SIZE(DW)) bus();

  model_matrix_streamer #(
    .DATA_SIZE (DW),
    .ADDR_SIZE (6)
  ) dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus)
  );

  typedef struct packed {
    logic [DW-1:0] data;
    logic          ien;
    logic          last;
  } exp_t;

  typedef struct packed {
    logic err;
    logic chk_lat;
  } stat_t;

  exp_t  exp_q[$];
  stat_t stat_q[$];
  exp_t  e_pop, hold_val;
  stat_t s_pop;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int last_hs_cyc = -10;
  int done_cnt = 0;
  int ops = 0;
  int out_cnt = 0;
  int in_rdy_cnt = 0;
  int ready_mode = 0;
  logic hold_pend = 1'b0;
  logic prev_ready = 1'b0;

  int e1[6]   = '{1, 2, 3, 4, 5, 6};
  bit ie1[6]  = '{1, 0, 0, 1, 0, 0};
  int e2[6]   = '{1, 4, 2, 5, 3, 6};
  bit ie2[6]  = '{1, 0, 1, 0, 1, 0};

  task automatic chk(string name, logic [DW-1:0] act, logic [DW-1:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  task automatic push_exp(logic [DW-1:0] d, logic ien, logic last);
    exp_q.push_back({d, ien, last});
  endtask

  task automatic push_stat(logic err, logic lat);
    stat_q.push_back({err, lat});
    ops++;
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // Sizes and mode are scrambled right after START to show they are latched.
  task automatic start_op(int si, int sj, logic tr);
    bus.SIZE_I_IN = DW'(si);
    bus.SIZE_J_IN = DW'(sj);
    bus.TRANSPOSE = tr;
    bus.START     = 1'b1;
    tick();
    bus.START     = 1'b0;
    bus.SIZE_I_IN = '1;
    bus.SIZE_J_IN = '1;
    bus.TRANSPOSE = ~tr;
  endtask

  task automatic send(logic [DW-1:0] v);
    bit hs = 1'b0;
    bus.DATA_IN       = v;
    bus.DATA_IN_VALID = 1'b1;
    for (int n = 0; n < 50 && !hs; n++) begin
      @(negedge CLK);
      hs = bus.DATA_IN_READY;
      tick();
    end
    bus.DATA_IN_VALID = 1'b0;
    checks++;
    if (!hs) begin
      errors++;
      $display("FAIL send_timeout: got no DATA_IN_READY expected handshake for %0h", v);
    end
  endtask

  task automatic wait_done(int target);
    int n = 0;
    while (done_cnt < target && n < 3000) begin
      @(negedge CLK);
      n++;
    end
    checks++;
    if (done_cnt < target) begin
      errors++;
      $display("FAIL done_timeout: got %0d completions expected %0d", done_cnt, target);
    end
    tick();
  endtask

  task automatic chk_reset_outputs(string name);
    chk({name, "_flags"}, DW'({bus.READY, bus.BUSY, bus.ERROR, bus.DATA_IN_READY,
                               bus.DATA_OUT_VALID, bus.DATA_OUT_I_ENABLE,
                               bus.DATA_OUT_J_ENABLE, bus.DATA_OUT_LAST}), '0);
    chk({name, "_data"}, bus.DATA_OUT, '0);
  endtask

  always @(posedge CLK) begin
    #1;
    if (ready_mode == 1) bus.DATA_OUT_READY = ~bus.DATA_OUT_READY;
    else                 bus.DATA_OUT_READY = 1'b1;
  end

  // Monitor: stall stability, element scoreboard and completion pulses.
  always @(negedge CLK) begin
    cyc++;
    if (RST) begin
      if (bus.DATA_IN_READY) in_rdy_cnt++;
      if (hold_pend) begin
        chk("stall_valid", DW'(bus.DATA_OUT_VALID), DW'(1));
        chk("stall_data", bus.DATA_OUT, hold_val.data);
        chk("stall_flags", DW'({bus.DATA_OUT_I_ENABLE, bus.DATA_OUT_LAST}),
            DW'({hold_val.ien, hold_val.last}));
      end
      hold_pend = bus.DATA_OUT_VALID && !bus.DATA_OUT_READY;
      hold_val  = {bus.DATA_OUT, bus.DATA_OUT_I_ENABLE, bus.DATA_OUT_LAST};
      if (bus.DATA_OUT_VALID && bus.DATA_OUT_READY) begin
        chk("j_enable", DW'(bus.DATA_OUT_J_ENABLE), DW'(1));
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_out: got %0h expected no element", bus.DATA_OUT);
        end else begin
          e_pop = exp_q.pop_front();
          $display("out #%0d data=%0h i_en=%0b last=%0b", out_cnt, bus.DATA_OUT,
                   bus.DATA_OUT_I_ENABLE, bus.DATA_OUT_LAST);
          chk("out_data", bus.DATA_OUT, e_pop.data);
          chk("out_i_enable", DW'(bus.DATA_OUT_I_ENABLE), DW'(e_pop.ien));
          chk("out_last", DW'(bus.DATA_OUT_LAST), DW'(e_pop.last));
          if (e_pop.last) last_hs_cyc = cyc;
          out_cnt++;
        end
      end
      if (bus.ERROR && !bus.READY) begin
        checks++;
        errors++;
        $display("FAIL error_without_ready: got ERROR=1 READY=0 expected ERROR only with READY");
      end
      if (bus.READY) begin
        chk("ready_pulse_width", DW'(prev_ready), DW'(0));
        if (stat_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_ready: got READY expected none");
        end else begin
          s_pop = stat_q.pop_front();
          $display("done #%0d error=%0b", done_cnt, bus.ERROR);
          chk("error_flag", DW'(bus.ERROR), DW'(s_pop.err));
          chk("busy_in_done", DW'(bus.BUSY), DW'(1));
          if (s_pop.chk_lat) chk("ready_latency", DW'(cyc - last_hs_cyc), DW'(1));
        end
        done_cnt++;
      end
      prev_ready = bus.READY;
    end else begin
      hold_pend  = 1'b0;
      prev_ready = 1'b0;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish expected completion within time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int base;
    bus.START          = 1'b0;
    bus.TRANSPOSE      = 1'b0;
    bus.SIZE_I_IN      = '0;
    bus.SIZE_J_IN      = '0;
    bus.DATA_IN        = '0;
    bus.DATA_IN_VALID  = 1'b0;
    bus.DATA_OUT_READY = 1'b1;
    repeat (3) tick();
    chk_reset_outputs("reset");
    RST = 1'b1;
    tick();

    // 1: row-major 2x3
    for (int k = 0; k < 6; k++) push_exp(DW'(e1[k]), ie1[k], k == 5);
    push_stat(1'b0, 1'b1);
    start_op(2, 3, 1'b0);
    for (int k = 0; k < 6; k++) send(DW'(k + 1));
    wait_done(ops);

    // 2: transposed 2x3
    for (int k = 0; k < 6; k++) push_exp(DW'(e2[k]), ie2[k], k == 5);
    push_stat(1'b0, 1'b1);
    start_op(2, 3, 1'b1);
    for (int k = 0; k < 6; k++) send(DW'(k + 1));
    wait_done(ops);

    // 3: row-major 3x3 with input gaps and toggling output ready
    ready_mode = 1;
    for (int k = 0; k < 9; k++) push_exp(DW'(10 + k), (k % 3) == 0, k == 8);
    push_stat(1'b0, 1'b1);
    start_op(3, 3, 1'b0);
    for (int k = 0; k < 9; k++) begin
      if (k % 2 == 1) repeat (2) tick();
      send(DW'(10 + k));
    end
    wait_done(ops);
    ready_mode = 0;
    tick();

    // 4: empty and oversized matrices move no data
    base = in_rdy_cnt;
    push_stat(1'b0, 1'b0);
    start_op(0, 5, 1'b0);
    wait_done(ops);
    chk("zero_size_in_ready", DW'(in_rdy_cnt - base), '0);
    base = in_rdy_cnt;
    push_stat(1'b1, 1'b0);
    start_op(9, 8, 1'b0);
    wait_done(ops);
    chk("oversize_in_ready", DW'(in_rdy_cnt - base), '0);

    // 5: full buffer 8x8 transposed
    for (int k = 0; k < 64; k++) push_exp(DW'((k % 8) * 8 + k / 8), (k % 8) == 0, k == 63);
    push_stat(1'b0, 1'b1);
    start_op(8, 8, 1'b1);
    for (int k = 0; k < 64; k++) send(DW'(k));
    wait_done(ops);

    // 6: reset in the middle of draining a 4x4, then a clean 2x2
    for (int k = 0; k < 16; k++) push_exp(DW'(k + 1), (k % 4) == 0, k == 15);
    push_stat(1'b0, 1'b1);
    start_op(4, 4, 1'b0);
    for (int k = 0; k < 16; k++) send(DW'(k + 1));
    base = out_cnt;
    for (int n = 0; n < 100 && out_cnt < base + 5; n++) @(negedge CLK);
    chk("mid_drain_progress", DW'(out_cnt - base), DW'(5));
    #2;
    RST = 1'b0;
    #1;
    chk_reset_outputs("mid_reset");
    exp_q.delete();
    stat_q.delete();
    ops = done_cnt;
    repeat (2) tick();
    RST = 1'b1;
    tick();
    for (int k = 0; k < 4; k++) push_exp(DW'(k + 1), (k % 2) == 0, k == 3);
    push_stat(1'b0, 1'b1);
    start_op(2, 2, 1'b0);
    for (int k = 0; k < 4; k++) send(DW'(k + 1));
    wait_done(ops);

    chk("leftover_expected", DW'(exp_q.size() + stat_q.size()), '0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
